// File: rtl/neuron_pkg.sv
// Shared types, default widths and the saturating adder for the output LIF neuron.
package neuron_pkg;

    typedef enum logic [1:0] {
        ST_INTEG  = 2'b00,
        ST_FIRE   = 2'b01,
        ST_REFRAC = 2'b10
    } state_e;

    localparam int DW_DEF = 4;
    localparam int WW_DEF = 4;
    localparam int ACC_W  = 10;

    // Unsigned add that clamps to the all-ones membrane value instead of wrapping.
    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                                 input logic [ACC_W-1:0] b);
        logic [ACC_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
    endfunction

endpackage

// File: rtl/lif_accum.sv
// Combinational MAC + leak + saturate datapath for the output neuron.
// Leak is active only when OUT_NEURON_LEAK_EN is defined.
module lif_accum
    import neuron_pkg::*;
#(
    parameter int DW         = DW_DEF,
    parameter int WW         = WW_DEF,
    parameter int T_SHIFT    = 4,
    parameter int LEAK_SHIFT = 2
) (
    input  logic [ACC_W-1:0] i_pot,
    input  logic [DW-1:0]    i_din,
    input  logic [WW-1:0]    i_w,
    input  logic             i_acc,
    input  logic [3:0]       i_t,
    output logic [ACC_W-1:0] o_nxt,
    output logic             o_ge_th
);

`ifdef OUT_NEURON_LEAK_EN
    localparam logic LEAK_EN = 1'b1;
`else
    localparam logic LEAK_EN = 1'b0;
`endif

    logic [ACC_W-1:0]   w_leak;
    logic [ACC_W-1:0]   w_leaked;
    logic [DW+WW-1:0]   w_prod;
    logic [ACC_W-1:0]   w_th;

    // Truncating shift means a potential below 2^LEAK_SHIFT leaks by zero and holds.
    assign w_leak   = (i_pot >> LEAK_SHIFT) & {ACC_W{LEAK_EN}};
    assign w_leaked = i_pot - w_leak;
    assign w_prod   = i_acc ? (DW+WW)'(i_din) * (DW+WW)'(i_w) : '0;
    assign o_nxt    = sat_add(w_leaked, ACC_W'(w_prod));
    assign w_th     = ACC_W'(i_t) << T_SHIFT;
    assign o_ge_th  = (o_nxt >= w_th);

endmodule

// File: rtl/output_lif_neuron.sv
// Output-layer leaky integrate-and-fire neuron: INTEG -> FIRE -> REFRAC state machine.
// Define OUT_NEURON_LEAK_EN to enable the per-cycle membrane leak.
module output_lif_neuron
    import neuron_pkg::*;
#(
    parameter int DW         = DW_DEF,
    parameter int WW         = WW_DEF,
    parameter int T_SHIFT    = 4,
    parameter int LEAK_SHIFT = 2,
    parameter int REFRAC_CYC = 3,
    parameter int CNT_W      = 8
) (
    input  logic             i_clk,
    input  logic             i_res,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [DW-1:0]    i_din,
    input  logic [WW-1:0]    i_w,
    input  logic [3:0]       i_t,
    input  logic             i_clr_cnt,
    output logic             o_spike,
    output logic [ACC_W-1:0] o_potential,
    output logic [CNT_W-1:0] o_spike_cnt,
    output logic             o_refrac
);

    localparam int RC_W = (REFRAC_CYC > 1) ? $clog2(REFRAC_CYC) : 1;
    localparam logic [RC_W-1:0]  RC_LOAD    = (REFRAC_CYC > 0) ? RC_W'(REFRAC_CYC - 1) : '0;
    localparam logic             HAS_REFRAC = (REFRAC_CYC > 0);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    state_e            r_state;
    state_e            w_state_nxt;
    logic [ACC_W-1:0]  r_pot;
    logic [ACC_W-1:0]  w_pot_nxt;
    logic [RC_W-1:0]   r_rc;
    logic [RC_W-1:0]   w_rc_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              r_spike;
    logic              r_in_ready;
    logic              r_refrac;
    logic              w_acc;
    logic [ACC_W-1:0]  w_accum_nxt;
    logic              w_ge_th;

    lif_accum #(
        .DW         (DW),
        .WW         (WW),
        .T_SHIFT    (T_SHIFT),
        .LEAK_SHIFT (LEAK_SHIFT)
    ) u_accum (
        .i_pot   (r_pot),
        .i_din   (i_din),
        .i_w     (i_w),
        .i_acc   (w_acc),
        .i_t     (i_t),
        .o_nxt   (w_accum_nxt),
        .o_ge_th (w_ge_th)
    );

    // Next-state, potential and refractory counter decode.
    always_comb begin
        w_state_nxt = r_state;
        w_pot_nxt   = r_pot;
        w_rc_nxt    = r_rc;
        w_acc       = 1'b0;
        case (r_state)
            ST_INTEG: begin
                w_acc     = i_in_valid;
                w_pot_nxt = w_accum_nxt;
                if (w_acc && (i_t != 4'd0) && w_ge_th) begin
                    w_state_nxt = ST_FIRE;
                end else begin
                    w_state_nxt = ST_INTEG;
                end
            end
            ST_FIRE: begin
                w_pot_nxt = '0;
                if (HAS_REFRAC) begin
                    w_state_nxt = ST_REFRAC;
                    w_rc_nxt    = RC_LOAD;
                end else begin
                    w_state_nxt = ST_INTEG;
                end
            end
            ST_REFRAC: begin
                w_pot_nxt = '0;
                if (r_rc == '0) begin
                    w_state_nxt = ST_INTEG;
                end else begin
                    w_rc_nxt = r_rc - RC_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_INTEG;
                w_pot_nxt   = '0;
            end
        endcase
    end

    // Spike counter: a clear coinciding with FIRE still counts that spike.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (r_state == ST_FIRE) begin
            if (i_clr_cnt) begin
                w_cnt_nxt = CNT_W'(1);
            end else if (r_cnt == CNT_MAX) begin
                w_cnt_nxt = CNT_MAX;
            end else begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
            end
        end else if (i_clr_cnt) begin
            w_cnt_nxt = '0;
        end else begin
            w_cnt_nxt = r_cnt;
        end
    end

    // State and output registers; outputs are decoded from the next state.
    always_ff @(posedge i_clk) begin
        if (i_res) begin
            r_state    <= ST_INTEG;
            r_pot      <= '0;
            r_rc       <= '0;
            r_cnt      <= '0;
            r_spike    <= 1'b0;
            r_in_ready <= 1'b1;
            r_refrac   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pot      <= w_pot_nxt;
            r_rc       <= w_rc_nxt;
            r_cnt      <= w_cnt_nxt;
            r_spike    <= (w_state_nxt == ST_FIRE);
            r_in_ready <= (w_state_nxt == ST_INTEG);
            r_refrac   <= (w_state_nxt != ST_INTEG);
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_spike     = r_spike;
    assign o_potential = r_pot;
    assign o_spike_cnt = r_cnt;
    assign o_refrac    = r_refrac;

endmodule
